// File: rtl/vga_text_pkg.sv
// Shared geometry, control codes and FSM state type for the text writer.
// Optional feature macro: VGA_TEXT_CLEAR_ON_WRAP_EN (clear destination row on row advance).
package vga_text_pkg;

  localparam int unsigned TEXT_COLS  = 40;
  localparam int unsigned TEXT_ROWS  = 30;
  localparam int unsigned TEXT_CELLS = TEXT_COLS * TEXT_ROWS;

  localparam int unsigned COL_W  = 6;
  localparam int unsigned ROW_W  = 5;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned CHAR_W = 7;
  localparam int unsigned CELL_W = 8;

  localparam logic [CHAR_W-1:0] CHAR_SPACE = 7'h20;
  localparam logic [CHAR_W-1:0] CHAR_TILDE = 7'h7E;
  localparam logic [CHAR_W-1:0] CHAR_BS    = 7'h08;
  localparam logic [CHAR_W-1:0] CHAR_LF    = 7'h0A;
  localparam logic [CHAR_W-1:0] CHAR_FF    = 7'h0C;
  localparam logic [CHAR_W-1:0] CHAR_CR    = 7'h0D;

  // Blank cell: space glyph, normal (non-inverted) colours.
  localparam logic [CELL_W-1:0] CELL_BLANK = {1'b0, CHAR_SPACE};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_SCREEN = 2'd1,
    CLR_ROW    = 2'd2
  } state_t;

endpackage

// File: rtl/vga_cell_addr.sv
// Combinational cell address: row*40 + col, formed as row*32 + row*8 + col.
// Ports: row (5b), col (6b) in; addr_c (11b) out.
module vga_cell_addr
  import vga_text_pkg::*;
(
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr_c
);

  assign addr_c = ADDR_W'({row, 5'b0}) + ADDR_W'({row, 3'b0}) + ADDR_W'(col);

endmodule

// File: rtl/vga_text_writer.sv
// Character-stream front end: accepts ASCII over valid/ready, tracks a cursor,
// interprets LF/CR/BS/FF and drives the text RAM write port.
// Ports: clock, reset (async, active-high); char_in, invert_in, char_valid in;
// char_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row out (all registered).
// Optional feature macro: VGA_TEXT_CLEAR_ON_WRAP_EN -- every row advance clears
// the destination row (CLR_ROW state); without it a row advance only moves the cursor.
module vga_text_writer
  import vga_text_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [CHAR_W-1:0] char_in,
  input  logic              invert_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CELL_W-1:0] wr_data,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row
);

  state_t             state;
  logic [ROW_W-1:0]   clr_row;
  logic [COL_W-1:0]   clr_col;
  logic [ROW_W-1:0]   next_row;
  logic [ROW_W-1:0]   cur_a_row;
  logic [COL_W-1:0]   cur_a_col;
  logic [ADDR_W-1:0]  cur_addr;
  logic [ADDR_W-1:0]  clr_addr;
  logic               accept;
  logic               is_print;
  logic               at_last_col;

  assign accept      = char_valid && char_ready;
  assign is_print    = (char_in >= CHAR_SPACE) && (char_in <= CHAR_TILDE);
  assign at_last_col = (cursor_col == COL_W'(TEXT_COLS - 1));
  assign next_row    = (cursor_row == ROW_W'(TEXT_ROWS - 1)) ? '0
                                                             : ROW_W'(cursor_row + 1'b1);

  // Target cell for writes issued from IDLE: BS writes one column left;
  // with row clearing, LF starts the clear at column 0 of the next row.
  always_comb begin
    cur_a_row = cursor_row;
    cur_a_col = cursor_col;
    if (char_in == CHAR_BS) cur_a_col = COL_W'(cursor_col - 1'b1);
`ifdef VGA_TEXT_CLEAR_ON_WRAP_EN
    if (char_in == CHAR_LF) begin
      cur_a_row = next_row;
      cur_a_col = '0;
    end
`endif
  end

  vga_cell_addr u_cur_addr (.row(cur_a_row), .col(cur_a_col), .addr_c(cur_addr));
  vga_cell_addr u_clr_addr (.row(clr_row),   .col(clr_col),   .addr_c(clr_addr));

  // Control FSM with registered outputs. Clears issue their first write on the
  // accepting edge so char_ready is low exactly while clear writes are in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      char_ready <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      clr_row    <= '0;
      clr_col    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_print) begin
              wr_en   <= 1'b1;
              wr_addr <= cur_addr;
              wr_data <= {invert_in, char_in};
              if (at_last_col) begin
                cursor_col <= '0;
                cursor_row <= next_row;
`ifdef VGA_TEXT_CLEAR_ON_WRAP_EN
                state      <= CLR_ROW;
                char_ready <= 1'b0;
                clr_row    <= next_row;
                clr_col    <= '0;
`endif
              end else begin
                cursor_col <= COL_W'(cursor_col + 1'b1);
              end
            end else begin
              case (char_in)
                CHAR_LF: begin
                  cursor_col <= '0;
                  cursor_row <= next_row;
`ifdef VGA_TEXT_CLEAR_ON_WRAP_EN
                  wr_en      <= 1'b1;
                  wr_addr    <= cur_addr;
                  wr_data    <= CELL_BLANK;
                  state      <= CLR_ROW;
                  char_ready <= 1'b0;
                  clr_row    <= next_row;
                  clr_col    <= COL_W'(1);
`endif
                end
                CHAR_CR: cursor_col <= '0;
                CHAR_BS: begin
                  if (cursor_col != '0) begin
                    cursor_col <= COL_W'(cursor_col - 1'b1);
                    wr_en      <= 1'b1;
                    wr_addr    <= cur_addr;
                    wr_data    <= CELL_BLANK;
                  end
                end
                CHAR_FF: begin
                  state      <= CLR_SCREEN;
                  char_ready <= 1'b0;
                  wr_en      <= 1'b1;
                  wr_addr    <= '0;
                  wr_data    <= CELL_BLANK;
                  clr_row    <= '0;
                  clr_col    <= COL_W'(1);
                end
                default: ;
              endcase
            end
          end
        end

        // clr_row reaching TEXT_ROWS means cell 1199 has been written.
        CLR_SCREEN: begin
          if (clr_row == ROW_W'(TEXT_ROWS)) begin
            state      <= IDLE;
            char_ready <= 1'b1;
            cursor_col <= '0;
            cursor_row <= '0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= clr_addr;
            wr_data <= CELL_BLANK;
            if (clr_col == COL_W'(TEXT_COLS - 1)) begin
              clr_col <= '0;
              clr_row <= ROW_W'(clr_row + 1'b1);
            end else begin
              clr_col <= COL_W'(clr_col + 1'b1);
            end
          end
        end

`ifdef VGA_TEXT_CLEAR_ON_WRAP_EN
        CLR_ROW: begin
          if (clr_col == COL_W'(TEXT_COLS)) begin
            state      <= IDLE;
            char_ready <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= clr_addr;
            wr_data <= CELL_BLANK;
            clr_col <= COL_W'(clr_col + 1'b1);
          end
        end
`endif

        default: begin
          state      <= IDLE;
          char_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed self-checking bench for vga_text_writer (default build, row clearing off).
module tb_vga_text_writer;

  logic        clock;
  logic        reset;
  logic [6:0]  char_in;
  logic        invert_in;
  logic        char_valid;
  logic        char_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;

  int n_cmp = 0;
  int n_err = 0;

  vga_text_writer dut (
    .clock      (clock),
    .reset      (reset),
    .char_in    (char_in),
    .invert_in  (invert_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one character for a single cycle; returns at the negedge after acceptance.
  task automatic send(input logic [6:0] c, input logic inv);
    @(negedge clock);
    char_in    = c;
    invert_in  = inv;
    char_valid = 1'b1;
    @(negedge clock);
    char_valid = 1'b0;
  endtask

  initial begin
    int n;
    int bad_addr;
    int bad_data;
    int bad_ready;
    int late_wr;

    reset      = 1'b1;
    char_in    = '0;
    invert_in  = 1'b0;
    char_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(char_ready), 32'd1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_addr",  32'(wr_addr), 32'd0);
    check("rst_data",  32'(wr_data), 32'd0);
    check("rst_col",   32'(cursor_col), 32'd0);
    check("rst_row",   32'(cursor_row), 32'd0);
    reset = 1'b0;

    // 'A' inverted at (0,0)
    send(7'h41, 1'b1);
    check("A_wr_en", 32'(wr_en), 32'd1);
    check("A_addr",  32'(wr_addr), 32'd0);
    check("A_data",  32'(wr_data), 32'hC1);
    check("A_col",   32'(cursor_col), 32'd1);
    check("A_row",   32'(cursor_row), 32'd0);
    @(negedge clock);
    check("A_wr_pulse", 32'(wr_en), 32'd0);

    // Fill to column 39, then 'Z' wraps to (0,1)
    for (int i = 0; i < 38; i++) send(7'h62, 1'b0);
    check("fill_col", 32'(cursor_col), 32'd39);
    send(7'h5A, 1'b0);
    check("Z_wr_en", 32'(wr_en), 32'd1);
    check("Z_addr",  32'(wr_addr), 32'd39);
    check("Z_data",  32'(wr_data), 32'h5A);
    check("Z_col",   32'(cursor_col), 32'd0);
    check("Z_row",   32'(cursor_row), 32'd1);
    check("Z_ready", 32'(char_ready), 32'd1);

    // LF x28 -> row 29, then 5 chars -> (5,29), then LF wraps to (0,0)
    for (int i = 0; i < 28; i++) send(7'h0A, 1'b0);
    check("lf_wr_en", 32'(wr_en), 32'd0);
    check("lf_row",   32'(cursor_row), 32'd29);
    for (int i = 0; i < 5; i++) send(7'h63, 1'b0);
    check("r29_col", 32'(cursor_col), 32'd5);
    send(7'h0A, 1'b0);
    check("wrap_wr_en", 32'(wr_en), 32'd0);
    check("wrap_col",   32'(cursor_col), 32'd0);
    check("wrap_row",   32'(cursor_row), 32'd0);

    // Move to (3,2), BS writes a blank at addr 82
    send(7'h0A, 1'b0);
    send(7'h0A, 1'b0);
    for (int i = 0; i < 3; i++) send(7'h64, 1'b0);
    send(7'h08, 1'b0);
    check("bs_wr_en", 32'(wr_en), 32'd1);
    check("bs_addr",  32'(wr_addr), 32'd82);
    check("bs_data",  32'(wr_data), 32'h20);
    check("bs_col",   32'(cursor_col), 32'd2);
    check("bs_row",   32'(cursor_row), 32'd2);

    // CR to column 0, BS at column 0 does nothing
    send(7'h0D, 1'b0);
    check("cr_wr_en", 32'(wr_en), 32'd0);
    check("cr_col",   32'(cursor_col), 32'd0);
    send(7'h08, 1'b0);
    check("bs0_wr_en", 32'(wr_en), 32'd0);
    check("bs0_col",   32'(cursor_col), 32'd0);
    check("bs0_row",   32'(cursor_row), 32'd2);

    // Ignored codes
    send(7'h7F, 1'b1);
    check("del_wr_en", 32'(wr_en), 32'd0);
    send(7'h01, 1'b0);
    check("soh_wr_en", 32'(wr_en), 32'd0);
    check("ign_col",   32'(cursor_col), 32'd0);
    check("ign_row",   32'(cursor_row), 32'd2);

    // FF: 1200 consecutive blank writes, addr 0..1199, char_valid held meanwhile
    send(7'h0C, 1'b0);
    check("ff_ready_fall", 32'(char_ready), 32'd0);
    n = 0; bad_addr = 0; bad_data = 0; bad_ready = 0;
    for (int k = 0; k < 1300; k++) begin
      if (wr_en) begin
        if (wr_addr !== 11'(n)) bad_addr++;
        if (wr_data !== 8'h20) bad_data++;
        if (char_ready !== 1'b0) bad_ready++;
        n++;
      end else if (char_ready) begin
        break;
      end
      if (k == 10) begin
        char_in    = 7'h51;
        char_valid = 1'b1;
      end
      if (k == 20) char_valid = 1'b0;
      @(negedge clock);
    end
    check("ff_count",     32'(n), 32'd1200);
    check("ff_bad_addr",  32'(bad_addr), 32'd0);
    check("ff_bad_data",  32'(bad_data), 32'd0);
    check("ff_bad_ready", 32'(bad_ready), 32'd0);
    check("ff_end_ready", 32'(char_ready), 32'd1);
    check("ff_end_col",   32'(cursor_col), 32'd0);
    check("ff_end_row",   32'(cursor_row), 32'd0);
    @(negedge clock);
    check("ff_after_wr_en", 32'(wr_en), 32'd0);

    // Reset in the middle of a clear
    send(7'h45, 1'b0);
    check("pre_col", 32'(cursor_col), 32'd1);
    send(7'h0C, 1'b0);
    n = 0;
    for (int k = 0; k < 1300; k++) begin
      if (wr_en) n++;
      if (n == 600) break;
      @(negedge clock);
    end
    check("mid_count", 32'(n), 32'd600);
    reset = 1'b1;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_ready", 32'(char_ready), 32'd1);
    late_wr = 0;
    repeat (3) begin
      @(negedge clock);
      if (wr_en) late_wr++;
    end
    reset = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (wr_en) late_wr++;
    end
    check("mid_late_writes", 32'(late_wr), 32'd0);
    check("mid_ready", 32'(char_ready), 32'd1);
    check("mid_col",   32'(cursor_col), 32'd0);
    check("mid_row",   32'(cursor_row), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
